instr_loader: RTL and testbench

//   Writer side of the CPU instruction store: receives a program as a byte stream
//   and assembles each 4-byte group into a 26-bit instruction word.

---
 rtl/instr_loader_if.sv | 29 ++
 rtl/instr_loader.sv | 122 ++++++++++++
 tb/tb_instr_loader.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/instr_loader_if.sv
// Loader-facing bundle: program byte stream in, instruction-memory write port and status out.
interface instr_loader_if #(
  parameter int unsigned ADDR_W  = 6,
  parameter int unsigned INSTR_W = 26
);
  logic               start;
  logic [6:0]         len;
  logic               byte_valid;
  logic [7:0]         byte_data;
  logic               byte_ready;
  logic               mem_we;
  logic [ADDR_W-1:0]  mem_addr;
  logic [INSTR_W-1:0] mem_wdata;
  logic               cpu_hold;
  logic               busy;
  logic               done;
  logic               err;
  logic [6:0]         word_cnt;

  modport master (
    output start, len, byte_valid, byte_data,
    input  byte_ready, mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, err, word_cnt
  );

  modport slave (
    input  start, len, byte_valid, byte_data,
    output byte_ready, mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, err, word_cnt
  );
endinterface

// File: rtl/instr_loader.sv
// Instruction store writer: packs big-endian byte groups into 26-bit words and writes
// them to instruction memory while holding the CPU in reset.
module instr_loader (
  input  logic          clk,
  input  logic          rst,
  instr_loader_if.slave bus
);
  localparam int unsigned ADDR_W  = 6;
  localparam int unsigned INSTR_W = 26;
  localparam int unsigned DEPTH   = 64;
  localparam int unsigned LEN_W   = 7;
  localparam int unsigned ASM_W   = INSTR_W - 8;

  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

  state_t           state;
  logic [LEN_W-1:0] len_q;
  logic [1:0]       idx;
  logic [ASM_W-1:0] asm_q;
  logic [LEN_W-1:0] word_cnt_inc_c;

  assign word_cnt_inc_c = bus.word_cnt + LEN_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      len_q          <= '0;
      idx            <= '0;
      asm_q          <= '0;
      bus.byte_ready <= 1'b0;
      bus.mem_we     <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_wdata  <= '0;
      bus.cpu_hold   <= 1'b0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.err        <= 1'b0;
      bus.word_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (bus.len > LEN_W'(DEPTH)) begin
              bus.err <= 1'b1;
            end else begin
              bus.err      <= 1'b0;
              bus.word_cnt <= '0;
              bus.busy     <= 1'b1;
              bus.cpu_hold <= 1'b1;
              idx          <= '0;
              len_q        <= bus.len;
              if (bus.len == '0) begin
                bus.done <= 1'b1;
                state    <= DONE;
              end else begin
                bus.byte_ready <= 1'b1;
                state          <= RECV;
              end
            end
          end
        end

        RECV: begin
          if (bus.byte_valid && bus.byte_ready) begin
            case (idx)
              2'd0: begin
                // Only two payload bits live in the first byte; anything else is a corrupt stream.
                if (bus.byte_data[7:2] != 6'd0) begin
                  bus.err        <= 1'b1;
                  bus.byte_ready <= 1'b0;
                  bus.cpu_hold   <= 1'b0;
                  bus.busy       <= 1'b0;
                  state          <= IDLE;
                end else begin
                  asm_q[ASM_W-1 -: 2] <= bus.byte_data[1:0];
                  idx                 <= 2'd1;
                end
              end
              2'd1: begin
                asm_q[15:8] <= bus.byte_data;
                idx         <= 2'd2;
              end
              2'd2: begin
                asm_q[7:0] <= bus.byte_data;
                idx        <= 2'd3;
              end
              default: begin
                bus.mem_we     <= 1'b1;
                bus.mem_addr   <= bus.word_cnt[ADDR_W-1:0];
                bus.mem_wdata  <= {asm_q, bus.byte_data};
                bus.byte_ready <= 1'b0;
                idx            <= 2'd0;
                state          <= WRITE;
              end
            endcase
          end
        end

        WRITE: begin
          bus.mem_we   <= 1'b0;
          bus.word_cnt <= word_cnt_inc_c;
          if (word_cnt_inc_c == len_q) begin
            bus.done <= 1'b1;
            state    <= DONE;
          end else begin
            bus.byte_ready <= 1'b1;
            state          <= RECV;
          end
        end

        DONE: begin
          bus.done     <= 1'b0;
          bus.cpu_hold <= 1'b0;
          bus.busy     <= 1'b0;
          state        <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: reset, single word, full 64-word load, stream error,
// zero/oversize length, and start while busy.
module tb_instr_loader;
  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   done_cnt;
  logic [5:0]  wr_addr[$];
  logic [25:0] wr_data[$];

  instr_loader_if bus ();

  instr_loader dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write and done observer, sampled mid-cycle
  always @(negedge clk) begin
    if (bus.mem_we) begin
      wr_addr.push_back(bus.mem_addr);
      wr_data.push_back(bus.mem_wdata);
    end
    if (bus.done) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    done_cnt = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'hFF;
    repeat (gap) tick();
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    n = 0;
    while (!bus.byte_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check("byte_ready_timeout", 32'(bus.byte_ready), 32'd1);
    tick();
    bus.byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [25:0] w, input int gap);
    send_byte({6'd0, w[25:24]}, gap);
    send_byte(w[23:16], gap);
    send_byte(w[15:8], gap);
    send_byte(w[7:0], gap);
  endtask

  task automatic pulse_start(input logic [6:0] l);
    bus.start = 1'b1;
    bus.len   = l;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!bus.done && n < 20) begin
      tick();
      n++;
    end
    check("done_seen", 32'(bus.done), 32'd1);
  endtask

  function automatic logic [25:0] pattern(input int w);
    return 26'((w * 32'h0013_579B) ^ 32'h02A5_5A5A);
  endfunction

  initial begin
    checks         = 0;
    errors         = 0;
    done_cnt       = 0;
    rst            = 1'b0;
    bus.start      = 1'b0;
    bus.len        = 7'd0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    tick();
    tick();
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_hold", 32'(bus.cpu_hold), 32'd0);
    rst = 1'b1;
    tick();

    // Reset in the middle of a word
    clear_log();
    pulse_start(7'd2);
    check("t1_hold", 32'(bus.cpu_hold), 32'd1);
    send_byte(8'h01, 0);
    send_byte(8'h22, 0);
    #2 rst = 1'b0;
    #1;
    check("t1_ready", 32'(bus.byte_ready), 32'd0);
    check("t1_hold0", 32'(bus.cpu_hold), 32'd0);
    check("t1_busy", 32'(bus.busy), 32'd0);
    check("t1_wcnt", 32'(bus.word_cnt), 32'd0);
    check("t1_addr", 32'(bus.mem_addr), 32'd0);
    check("t1_wdata", 32'(bus.mem_wdata), 32'd0);
    tick();
    rst = 1'b1;
    bus.byte_valid = 1'b1;
    tick();
    check("t1_idle_ready", 32'(bus.byte_ready), 32'd0);
    bus.byte_valid = 1'b0;
    check("t1_no_write", 32'(wr_addr.size()), 32'd0);

    // Single word, write latency and done timing
    clear_log();
    pulse_start(7'd1);
    send_byte(8'h03, 0);
    send_byte(8'hAB, 0);
    send_byte(8'hCD, 0);
    send_byte(8'hEF, 0);
    check("t2_we", 32'(bus.mem_we), 32'd1);
    check("t2_addr", 32'(bus.mem_addr), 32'd0);
    check("t2_wdata", 32'(bus.mem_wdata), 32'h03AB_CDEF);
    check("t2_ready", 32'(bus.byte_ready), 32'd0);
    tick();
    check("t2_done", 32'(bus.done), 32'd1);
    check("t2_hold_done", 32'(bus.cpu_hold), 32'd1);
    check("t2_we_off", 32'(bus.mem_we), 32'd0);
    check("t2_wcnt", 32'(bus.word_cnt), 32'd1);
    tick();
    check("t2_done_off", 32'(bus.done), 32'd0);
    check("t2_hold_off", 32'(bus.cpu_hold), 32'd0);
    check("t2_busy_off", 32'(bus.busy), 32'd0);
    check("t2_addr_hold", 32'(bus.mem_addr), 32'd0);

    // Full 64-word load with ragged byte_valid
    clear_log();
    pulse_start(7'd64);
    for (int w = 0; w < 64; w++) send_word(pattern(w), int'($urandom_range(0, 2)));
    wait_done();
    check("t3_wcnt", 32'(bus.word_cnt), 32'd64);
    tick();
    check("t3_hold_off", 32'(bus.cpu_hold), 32'd0);
    check("t3_nwr", 32'(wr_addr.size()), 32'd64);
    check("t3_ndone", 32'(done_cnt), 32'd1);
    for (int w = 0; w < 64 && w < wr_addr.size(); w++) begin
      check($sformatf("t3_addr%0d", w), 32'(wr_addr[w]), 32'(w));
      check($sformatf("t3_data%0d", w), 32'(wr_data[w]), 32'(pattern(w)));
    end

    // Bad leading byte on the second word
    clear_log();
    pulse_start(7'd2);
    send_word(26'h1234567, 0);
    send_byte(8'h04, 0);
    check("t4_err", 32'(bus.err), 32'd1);
    check("t4_hold", 32'(bus.cpu_hold), 32'd0);
    check("t4_busy", 32'(bus.busy), 32'd0);
    check("t4_wcnt", 32'(bus.word_cnt), 32'd1);
    tick();
    tick();
    check("t4_nwr", 32'(wr_addr.size()), 32'd1);
    check("t4_ndone", 32'(done_cnt), 32'd0);
    check("t4_err_sticky", 32'(bus.err), 32'd1);

    // Zero length, then oversize length
    clear_log();
    pulse_start(7'd0);
    check("t5_err_clr", 32'(bus.err), 32'd0);
    wait_done();
    tick();
    check("t5_busy", 32'(bus.busy), 32'd0);
    check("t5_nwr", 32'(wr_addr.size()), 32'd0);
    check("t5_ndone", 32'(done_cnt), 32'd1);
    pulse_start(7'd65);
    check("t5_err65", 32'(bus.err), 32'd1);
    check("t5_busy65", 32'(bus.busy), 32'd0);
    tick();
    check("t5_busy65b", 32'(bus.busy), 32'd0);
    check("t5_hold65", 32'(bus.cpu_hold), 32'd0);

    // Start during RECV is ignored; then back-to-back start after done
    clear_log();
    pulse_start(7'd2);
    send_byte(8'h02, 0);
    pulse_start(7'd1);
    send_byte(8'h55, 1);
    send_byte(8'h66, 0);
    send_byte(8'h77, 0);
    send_word(26'h0C0FFEE, 0);
    wait_done();
    check("t6_wcnt", 32'(bus.word_cnt), 32'd2);
    check("t6_nwr", 32'(wr_addr.size()), 32'd2);
    if (wr_data.size() == 2) begin
      check("t6_data0", 32'(wr_data[0]), 32'h0255_6677);
      check("t6_data1", 32'(wr_data[1]), 32'h00C0_FFEE);
      check("t6_addr1", 32'(wr_addr[1]), 32'd1);
    end
    tick();
    pulse_start(7'd1);
    check("t6_b2b_busy", 32'(bus.busy), 32'd1);
    check("t6_b2b_ready", 32'(bus.byte_ready), 32'd1);
    send_word(26'h2000001, 0);
    wait_done();
    check("t6_b2b_wcnt", 32'(bus.word_cnt), 32'd1);
    check("t6_b2b_nwr", 32'(wr_addr.size()), 32'd3);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
